register_file: RTL

- Two-read, one-write integer register file. It supplies the ALU `a`/`b` operands and receives the ALU `result` at writeback, so it is the other end of the ALU datapath.
- Register 0 is hardwired to zero.
- A per-register pending scoreboard tracks in-flight writes, so the core can stall on read-after-write hazards.
- Sits between decode (read and reserve) and writeback (write) in the core.

---
 rtl/register_file_pkg.sv | 12 +
 rtl/register_file_if.sv | 39 +++
 rtl/comparator_eq.sv | 12 +
 rtl/register_file_decoder.sv | 17 +
 rtl/register_file.sv | 92 +++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Register file shared types: address width, address type and the x0 constant.
// Decode and the ALU import the same definitions.
package regfile_pkg;

  localparam int NREGS_DEF  = 32;
  localparam int REG_ADDR_W = $clog2(NREGS_DEF);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback side of the register file: read, reserve and write ports.
// The master side is decode plus writeback; the slave side is the register file.
interface register_file_if
  import regfile_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = REG_ADDR_W
) ();

  logic [AW-1:0] rd_addr0;
  logic [AW-1:0] rd_addr1;
  logic [N-1:0]  rd_data0;
  logic [N-1:0]  rd_data1;
  logic          busy0;
  logic          busy1;
  logic          wr_ena;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          rsv_ena;
  logic [AW-1:0] rsv_addr;
  logic          rsv_conflict;

  modport master (
    output rd_addr0, rd_addr1,
    output wr_ena, wr_addr, wr_data,
    output rsv_ena, rsv_addr,
    input  rd_data0, rd_data1,
    input  busy0, busy1, rsv_conflict
  );

  modport slave (
    input  rd_addr0, rd_addr1,
    input  wr_ena, wr_addr, wr_data,
    input  rsv_ena, rsv_addr,
    output rd_data0, rd_data1,
    output busy0, busy1, rsv_conflict
  );

endinterface

// File: rtl/comparator_eq.sv
// Equality comparator used for the write-to-read bypass address match.
module comparator_eq #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/register_file_decoder.sv
// Enabled one-hot address decoder; bit 0 is forced low so x0 never updates.
module decoder_onehot #(
  parameter int AW   = 5,
  parameter int NOUT = 32
) (
  input  logic            ena,
  input  logic [AW-1:0]   addr,
  output logic [NOUT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (ena) onehot[addr] = 1'b1;
    onehot[0] = 1'b0;
  end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with x0 hardwired to zero and a
// per-register pending scoreboard for read-after-write stalls.
module register_file
  import regfile_pkg::*;
#(
  parameter int N      = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [N-1:0]     regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] wr_vec;
  logic [NREGS-1:0] rsv_vec;
  logic             conflict;
  logic             hit0;
  logic             hit1;
  logic             byp0;
  logic             byp1;
  logic             nz0;
  logic             nz1;

  decoder_onehot #(.AW(AW), .NOUT(NREGS)) u_wr_dec (
    .ena    (bus.wr_ena),
    .addr   (bus.wr_addr),
    .onehot (wr_vec)
  );

  decoder_onehot #(.AW(AW), .NOUT(NREGS)) u_rsv_dec (
    .ena    (bus.rsv_ena),
    .addr   (bus.rsv_addr),
    .onehot (rsv_vec)
  );

  comparator_eq #(.W(AW)) u_eq0 (
    .a  (bus.wr_addr),
    .b  (bus.rd_addr0),
    .eq (hit0)
  );

  comparator_eq #(.W(AW)) u_eq1 (
    .a  (bus.wr_addr),
    .b  (bus.rd_addr1),
    .eq (hit1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      regs[0] <= '0;
      for (int i = 1; i < NREGS; i++)
        if (wr_vec[i]) regs[i] <= bus.wr_data;
    end
  end

  // A same-cycle reserve re-arms the bit the write just retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      conflict <= 1'b0;
    end else begin
      pending  <= (pending & ~wr_vec) | rsv_vec;
      conflict <= conflict | (|(rsv_vec & pending & ~wr_vec));
    end
  end

  assign nz0  = (bus.rd_addr0 != '0);
  assign nz1  = (bus.rd_addr1 != '0);
  assign byp0 = BYPASS && bus.wr_ena && hit0 && nz0;
  assign byp1 = BYPASS && bus.wr_ena && hit1 && nz1;

  always_comb begin
    bus.rd_data0 = '0;
    bus.rd_data1 = '0;
    if (byp0)     bus.rd_data0 = bus.wr_data;
    else if (nz0) bus.rd_data0 = regs[bus.rd_addr0];
    if (byp1)     bus.rd_data1 = bus.wr_data;
    else if (nz1) bus.rd_data1 = regs[bus.rd_addr1];
  end

  assign bus.busy0        = nz0 && pending[bus.rd_addr0] && !byp0;
  assign bus.busy1        = nz1 && pending[bus.rd_addr1] && !byp1;
  assign bus.rsv_conflict = conflict;

endmodule
